// File: rtl/piso_tx_if.sv
// ----------------------------------------------------------------------------
// piso_tx_if : parallel-word handshake between a word producer and piso_tx.
//   din        producer -> tx   parallel word to transmit
//   din_valid  producer -> tx   din holds a word to send
//   din_ready  tx -> producer   transmitter can take a word this cycle
// Modports: master = word producer, slave = transmitter.
// ----------------------------------------------------------------------------
interface piso_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/piso_tx.sv
// ----------------------------------------------------------------------------
// piso_tx : parallel-in, serial-out framed transmitter.
// Sends start bit (0), WIDTH data bits, stop bit (1), one bit per shift_en
// pulse, then returns the line to idle-high.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   bus       word handshake (din, din_valid, din_ready), slave side
//   shift_en  bit-rate strobe
//   sdo       serial data out (registered, idle high)
//   busy      frame in progress
//   done      one-cycle pulse when the stop bit period ends
// ----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    piso_tx_if.slave      bus,
    input  logic          shift_en,
    output logic          sdo,
    output logic          busy,
    output logic          done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // Bit that goes on the line next, taken from the leading end of the word.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Word after the leading bit has been consumed.
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic             sdo_r, sdo_s;
    logic             busy_r, busy_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shreg_s = shreg_r;
        sdo_s   = sdo_r;
        busy_s  = busy_r;
        ready_s = ready_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // shift_en is deliberately ignored in the accept cycle.
                if (bus.din_valid) begin
                    state_s = ST_START;
                    shreg_s = bus.din;
                    cnt_s   = CNT_ZERO;
                    sdo_s   = 1'b0;
                    busy_s  = 1'b1;
                    ready_s = 1'b0;
                end else begin
                    sdo_s   = 1'b1;
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end
            ST_START: begin
                if (shift_en) begin
                    state_s = ST_DATA;
                    sdo_s   = head_bit(shreg_r);
                    shreg_s = shift_next(shreg_r);
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                // cnt_r is the index of the data bit currently on the line.
                if (shift_en) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_STOP;
                        sdo_s   = 1'b1;
                    end else begin
                        sdo_s   = head_bit(shreg_r);
                        shreg_s = shift_next(shreg_r);
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (shift_en) begin
                    state_s = ST_IDLE;
                    sdo_s   = 1'b1;
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                shreg_s = '0;
                sdo_s   = 1'b1;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            shreg_r <= '0;
            sdo_r   <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
            sdo_r   <= sdo_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
            done_r  <= done_s;
        end
    end

    assign bus.din_ready = ready_r;
    assign sdo           = sdo_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// ----------------------------------------------------------------------------
// tb_piso_tx : bench for piso_tx. Two instances (MSB-first and LSB-first)
// see identical stimulus. A frame-level reference model (list of line bits
// per frame plus a pulse position) predicts every output each cycle; table
// vectors additionally pin exact bit sequences and frame lengths.
// ----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W  = 8;
    localparam int FL = W + 2;

    logic         clk;
    logic         rst;
    logic         shift_en;
    logic [W-1:0] din;
    logic         din_valid;
    logic         sdo_m, busy_m, done_m;
    logic         sdo_l, busy_l, done_l;

    int errors;
    int checks;

    piso_tx_if #(.WIDTH(W)) if_m ();
    piso_tx_if #(.WIDTH(W)) if_l ();

    assign if_m.din       = din;
    assign if_m.din_valid = din_valid;
    assign if_l.din       = din;
    assign if_l.din_valid = din_valid;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bus(if_m.slave), .shift_en(shift_en),
        .sdo(sdo_m), .busy(busy_m), .done(done_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bus(if_l.slave), .shift_en(shift_en),
        .sdo(sdo_l), .busy(busy_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic m_busy;
    logic m_done;
    int   m_pos;
    logic fm [FL];
    logic fl [FL];

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_pos  = 0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!m_busy) begin
            if (din_valid) begin
                m_busy = 1'b1;
                m_pos  = 0;
                fm[0] = 1'b0;
                fl[0] = 1'b0;
                for (int i = 0; i < W; i++) begin
                    fm[1+i] = din[W-1-i];
                    fl[1+i] = din[i];
                end
                fm[FL-1] = 1'b1;
                fl[FL-1] = 1'b1;
            end
        end else if (shift_en) begin
            m_pos = m_pos + 1;
            if (m_pos == FL) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    function automatic logic exp_sdo(input logic msb);
        if (!m_busy) return 1'b1;
        return msb ? fm[m_pos] : fl[m_pos];
    endfunction

    task automatic chk(input string name, input logic act, input logic expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    task automatic check_model();
        chk("m.sdo",   sdo_m,          exp_sdo(1'b1));
        chk("l.sdo",   sdo_l,          exp_sdo(1'b0));
        chk("m.busy",  busy_m,         m_busy);
        chk("l.busy",  busy_l,         m_busy);
        chk("m.ready", if_m.din_ready, !m_busy);
        chk("l.ready", if_l.din_ready, !m_busy);
        chk("m.done",  done_m,         m_done);
        chk("l.done",  done_l,         m_done);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        @(negedge clk);
        check_model();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [W-1:0] din;
        int           period;
        logic [9:0]   exp_msb;   // line bits after accept, first bit at [9]
        logic [9:0]   exp_lsb;
    } vec_t;

    vec_t vecs [5];

    task automatic run_frame(input vec_t v);
        din       = v.din;
        din_valid = 1'b1;
        shift_en  = (v.period == 1);   // accept-cycle strobe must be ignored
        cyc();
        din_valid = 1'b0;
        din       = ~v.din;
        for (int b = 0; b < FL; b++) begin
            for (int k = 0; k < v.period; k++) begin
                chk("tbl.sdo_m", sdo_m,  v.exp_msb[9-b]);
                chk("tbl.sdo_l", sdo_l,  v.exp_lsb[9-b]);
                chk("tbl.busy",  busy_m, 1'b1);
                shift_en = (k == v.period - 1);
                cyc();
            end
        end
        chk("tbl.done",  done_m,         1'b1);
        chk("tbl.ready", if_l.din_ready, 1'b1);
        chk("tbl.busy0", busy_m,         1'b0);
        shift_en = 1'b0;
        cyc();
        chk("tbl.done1", done_m, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        shift_en  = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        model_reset();

        vecs[0] = '{din: 8'hC5, period: 1, exp_msb: 10'b0110001011, exp_lsb: 10'b0101000111};
        vecs[1] = '{din: 8'h01, period: 4, exp_msb: 10'b0000000011, exp_lsb: 10'b0100000001};
        vecs[2] = '{din: 8'hA6, period: 2, exp_msb: 10'b0101001101, exp_lsb: 10'b0011001011};
        vecs[3] = '{din: 8'h00, period: 1, exp_msb: 10'b0000000001, exp_lsb: 10'b0000000001};
        vecs[4] = '{din: 8'hFF, period: 3, exp_msb: 10'b0111111111, exp_lsb: 10'b0111111111};

        // Reset held 3 cycles, then idle with no words offered.
        @(negedge clk);
        chk("rst.sdo",   sdo_m,          1'b1);
        chk("rst.ready", if_m.din_ready, 1'b1);
        chk("rst.busy",  busy_l,         1'b0);
        chk("rst.done",  done_l,         1'b0);
        cyc(); cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cyc();

        // Table frames, including 4-cycle rate gating.
        foreach (vecs[i]) run_frame(vecs[i]);

        // Back-to-back: FF accepted, 00 offered mid-frame and held through done.
        din       = 8'hFF;
        din_valid = 1'b1;
        shift_en  = 1'b1;
        cyc();
        din = 8'h00;
        for (int b = 0; b < FL; b++) begin
            chk("b2b.f1_sdo", sdo_m, (b == 0) ? 1'b0 : 1'b1);
            cyc();
        end
        chk("b2b.done",  done_m, 1'b1);
        chk("b2b.idle",  sdo_m,  1'b1);
        cyc();
        din_valid = 1'b0;
        chk("b2b.start", sdo_m,  1'b0);
        chk("b2b.busy",  busy_m, 1'b1);
        for (int b = 0; b < FL; b++) begin
            chk("b2b.f2_sdo", sdo_l, (b == FL - 1) ? 1'b1 : 1'b0);
            cyc();
        end
        chk("b2b.done2", done_l, 1'b1);
        shift_en = 1'b0;
        cyc();

        // Reset during data bit 3: immediate idle, no done, clean next frame.
        din       = 8'hA6;
        din_valid = 1'b1;
        shift_en  = 1'b1;
        cyc();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("mid.in_data", busy_m, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid.sdo",   sdo_m,          1'b1);
        chk("mid.sdo_l", sdo_l,          1'b1);
        chk("mid.busy",  busy_m,         1'b0);
        chk("mid.ready", if_m.din_ready, 1'b1);
        chk("mid.done",  done_m,         1'b0);
        @(negedge clk);
        cyc();
        rst = 1'b1;
        cyc();
        run_frame(vecs[0]);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 3) == 0);
            shift_en  = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in, serial-out framed transmitter. It drives a single-bit serial line, one bit per rate-enable pulse, to a flop-based serial receiver elsewhere in the design. A parallel word is accepted through a valid/ready handshake. The word is sent as a start bit, then WIDTH data bits, then a stop bit, and the line then returns to idle-high.

Parameters:
- WIDTH, 8, data bits per frame (≥2).
- MSB_FIRST, 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a word.
- shift_en  input  1  bit-rate strobe; one bit period per cycle with shift_en=1.
- sdo  output  1  serial data out, registered.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, bit counter 0, shift register 0.
  - sdo=1, din_ready=1, busy=0, done=0.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 and no done pulse is produced.
- All outputs are registered and change only on rising clk edges, except for reset.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - sdo=1, din_ready=1, busy=0.
  - At an edge with din_valid=1, din is latched into the shift register and the state goes to START.
  - After that edge: sdo=0, busy=1, din_ready=0.
  - shift_en in the accept cycle is ignored.
- START:
  - sdo holds 0.
  - At the next edge with shift_en=1: go to DATA, drive the first data bit (per MSB_FIRST), counter=0.
- DATA:
  - At each edge with shift_en=1: shift out the next bit and increment the counter.
  - When counter=WIDTH-1 with shift_en=1: go to STOP, sdo=1.
- STOP:
  - sdo holds 1.
  - At the next edge with shift_en=1: go to IDLE, done=1 for exactly one cycle, busy=0, din_ready=1.
- With shift_en=0 the state, counter and sdo hold indefinitely; no timeout.
- A frame occupies exactly WIDTH+2 shift_en pulses after acceptance. sdo is 0 for the whole START period and 1 for the whole STOP period.
- din and din_valid are ignored while din_ready=0. There is no buffering; a word offered while busy is not latched.
- Back-to-back frames:
  - A word held valid during the done cycle is accepted at that edge, since din_ready=1 in that cycle.
  - sdo then drops to 0 immediately.
  - Minimum idle-high time between frames is therefore one clock, not one bit period.
- The counter is sized to hold WIDTH-1 and does not wrap during a frame; it is cleared on accept and on reset.

Test Plan:
1. Reset then idle: hold rst=0 for 3 cycles, release; keep din_valid=0 for 10 cycles → sdo=1, din_ready=1, busy=0, done=0 throughout.
2. MSB-first frame: WIDTH=8, MSB_FIRST=1, din=8'hC5, din_valid one cycle, shift_en=1 constantly → sdo over successive cycles = 0,1,1,0,0,0,1,0,1,1; done pulses once, 10 cycles after accept; busy high 10 cycles.
3. LSB-first frame: MSB_FIRST=0, din=8'hC5 → sdo = 0,1,0,1,0,0,0,1,1,1; then din_ready=1.
4. Rate gating: shift_en=1 every 4th cycle, din=8'h01, MSB_FIRST=1 → each bit is held 4 cycles; frame lasts 40 cycles; sdo=1 only during the last data bit and the stop bit.
5. Back-to-back and ignore-while-busy:
   - din=8'hFF accepted; din changes to 8'h00 with din_valid=1 mid-frame → the 8'h00 is not sent during frame 1.
   - din_valid held through the done cycle → the second frame (8'h00) starts the next cycle with start bit 0.
6. Reset mid-frame: assert rst=0 during DATA bit 3 between clock edges → sdo=1, busy=0, din_ready=1 immediately; no done; the next accepted word transmits correctly from its start bit.
